packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler_if.sv | 40 ++++
 rtl/packet_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_packet_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_scheduler_if.sv
// packet_scheduler_if
//   Bundles the scheduler's data-path and control signals into one port.
//   master: the environment side. It drives the field/slot pulses, the sample
//           stream and the InfoFrame configuration, and observes the packet result.
//   slave : the scheduler side. It observes the inputs, drives sample_ready and
//           the registered packet outputs.
interface packet_scheduler_if #(
  parameter int NUM_INFOFRAMES  = 8,
  parameter int AUDIO_BIT_WIDTH = 24
);
  logic                          video_field_end;
  logic                          packet_enable;
  logic                          acr_request;
  logic                          sample_valid;
  logic                          sample_ready;
  logic [AUDIO_BIT_WIDTH-1:0]    sample_left;
  logic [AUDIO_BIT_WIDTH-1:0]    sample_right;
  logic [NUM_INFOFRAMES-1:0]     infoframe_enable;
  logic [8*NUM_INFOFRAMES-1:0]   infoframe_type;
  logic [7:0]                    packet_type;
  logic [3:0]                    packet_source;
  logic [191:0]                  audio_group;
  logic [3:0]                    audio_present;
  logic [7:0]                    frame_counter;
  logic [7:0]                    missed_count;

  modport master (
    output video_field_end, packet_enable, acr_request, sample_valid,
           sample_left, sample_right, infoframe_enable, infoframe_type,
    input  sample_ready, packet_type, packet_source, audio_group,
           audio_present, frame_counter, missed_count
  );

  modport slave (
    input  video_field_end, packet_enable, acr_request, sample_valid,
           sample_left, sample_right, infoframe_enable, infoframe_type,
    output sample_ready, packet_type, packet_source, audio_group,
           audio_present, frame_counter, missed_count
  );
endinterface

// File: rtl/packet_scheduler.sv
// packet_scheduler
//   Chooses what goes into each packet slot. The choice is one of clock
//   regeneration (ACR), a group of up to four buffered stereo audio samples,
//   an armed InfoFrame, or a null packet. Audio samples are queued in a small
//   FIFO. InfoFrame slots re-arm every INFOFRAME_PERIOD fields. A slot that is
//   still unsent and enabled when re-armed is counted as missed.
// Ports
//   clk_pixel          pixel clock, the only clock
//   reset              asynchronous, active-high
//   bus.video_field_end  one-cycle end-of-field pulse
//   bus.packet_enable    one-cycle pulse that opens a packet slot
//   bus.acr_request      pulse requesting an ACR packet
//   bus.sample_valid/ready, sample_left/right   stereo sample push handshake
//   bus.infoframe_enable/type                  per-slot enable and type byte
//   bus.packet_type/source, audio_group/present, frame_counter
//                        result of the last arbitration, held until the next one
//   bus.missed_count     saturating count of InfoFrames not sent in time
module packet_scheduler #(
  parameter int NUM_INFOFRAMES   = 8,
  parameter int AUDIO_BIT_WIDTH  = 24,
  parameter int FIFO_DEPTH       = 8,
  parameter int INFOFRAME_PERIOD = 1
) (
  input  logic               clk_pixel,
  input  logic               reset,
  packet_scheduler_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    SEL_NULL,
    SEL_ACR,
    SEL_AUDIO_FULL,
    SEL_AUDIO_PART,
    SEL_INFO
  } sel_e;

  // sample storage, {right, left} left-justified to 24 bits
  logic [23:0]                 r_fifo_l [FIFO_DEPTH];
  logic [23:0]                 r_fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;

  logic                        r_acr_pending;
  logic [1:0]                  r_stale;
  logic [3:0]                  r_field_cnt;
  logic [NUM_INFOFRAMES-1:0]   r_pending;
  logic [7:0]                  r_frame_next;

  logic [7:0]                  r_packet_type;
  logic [3:0]                  r_packet_source;
  logic [191:0]                r_audio_group;
  logic [3:0]                  r_audio_present;
  logic [7:0]                  r_frame_counter;
  logic [7:0]                  r_missed_count;

  logic                        w_ready;
  logic                        w_push;
  logic [23:0]                 w_left24;
  logic [23:0]                 w_right24;
  logic                        w_short;
  sel_e                        w_sel;
  logic                        w_audio_sel;
  logic [2:0]                  w_pop_n;
  logic [2:0]                  w_pop;
  logic [NUM_INFOFRAMES-1:0]   w_if_avail;
  logic                        w_if_hit;
  logic [3:0]                  w_if_idx;
  logic [7:0]                  w_if_type;
  logic [NUM_INFOFRAMES-1:0]   w_if_onehot;
  logic [PTR_W-1:0]            w_rd_idx [4];
  logic [191:0]                w_group;
  logic [3:0]                  w_present;
  logic [7:0]                  w_type;
  logic [8:0]                  w_fc_sum;
  logic [7:0]                  w_fc_next;
  logic                        w_field_wrap;
  logic [NUM_INFOFRAMES-1:0]   w_pend_after;
  logic [NUM_INFOFRAMES-1:0]   w_miss_vec;
  logic [4:0]                  w_miss_pc;
  logic [8:0]                  w_miss_sum;

  assign w_ready   = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push    = bus.sample_valid && w_ready;
  assign w_left24  = 24'(bus.sample_left)  << (24 - AUDIO_BIT_WIDTH);
  assign w_right24 = 24'(bus.sample_right) << (24 - AUDIO_BIT_WIDTH);
  assign w_short   = (r_count != '0) && (r_count < CNT_W'(4));

  // Lowest-numbered armed and enabled slot wins. The loop runs downward so
  // the last hit written is the lowest index.
  always_comb begin
    w_if_avail  = r_pending & bus.infoframe_enable;
    w_if_hit    = 1'b0;
    w_if_idx    = '0;
    w_if_type   = '0;
    w_if_onehot = '0;
    for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
      if (w_if_avail[i]) begin
        w_if_hit       = 1'b1;
        w_if_idx       = 4'(i);
        w_if_type      = bus.infoframe_type[8*i +: 8];
        w_if_onehot    = '0;
        w_if_onehot[i] = 1'b1;
      end
    end
  end

  // The slot being arbitrated counts toward staleness. r_stale holds the
  // number of earlier slots that already skipped a short FIFO, so a partial
  // group goes out on the second consecutive slot that finds 1..3 samples.
  always_comb begin
    w_sel   = SEL_NULL;
    w_pop_n = '0;
    if (r_acr_pending || bus.acr_request) begin
      w_sel = SEL_ACR;
    end else if (r_count >= CNT_W'(4)) begin
      w_sel   = SEL_AUDIO_FULL;
      w_pop_n = 3'd4;
    end else if (w_short && (r_stale != 2'd0)) begin
      w_sel   = SEL_AUDIO_PART;
      w_pop_n = 3'(r_count);
    end else if (w_if_hit) begin
      w_sel = SEL_INFO;
    end
  end

  assign w_audio_sel = (w_sel == SEL_AUDIO_FULL) || (w_sel == SEL_AUDIO_PART);
  assign w_pop       = bus.packet_enable ? w_pop_n : 3'd0;

  always_comb begin
    w_group   = '0;
    w_present = '0;
    for (int k = 0; k < 4; k++) begin
      w_rd_idx[k] = r_rd_ptr + PTR_W'(k);
      if (3'(k) < w_pop_n) begin
        w_group[48*k +: 24]      = r_fifo_l[w_rd_idx[k]];
        w_group[48*k + 24 +: 24] = r_fifo_r[w_rd_idx[k]];
        w_present[k]             = 1'b1;
      end
    end
  end

  always_comb begin
    w_type = 8'h00;
    case (w_sel)
      SEL_ACR:        w_type = 8'h01;
      SEL_AUDIO_FULL: w_type = 8'h02;
      SEL_AUDIO_PART: w_type = 8'h02;
      SEL_INFO:       w_type = w_if_type;
      default:        w_type = 8'h00;
    endcase
  end

  // IEC 60958 block is 192 frames
  assign w_fc_sum  = {1'b0, r_frame_next} + 9'(w_pop_n);
  assign w_fc_next = (w_fc_sum >= 9'd192) ? 8'(w_fc_sum - 9'd192) : w_fc_sum[7:0];

  // A slot served in this same cycle counts as sent, not missed.
  assign w_field_wrap = bus.video_field_end && (r_field_cnt == 4'(INFOFRAME_PERIOD - 1));
  assign w_pend_after = (bus.packet_enable && (w_sel == SEL_INFO)) ?
                        (r_pending & ~w_if_onehot) : r_pending;
  assign w_miss_vec   = w_pend_after & bus.infoframe_enable;

  always_comb begin
    w_miss_pc = '0;
    for (int i = 0; i < NUM_INFOFRAMES; i++) begin
      w_miss_pc = w_miss_pc + 5'(w_miss_vec[i]);
    end
  end

  assign w_miss_sum = {1'b0, r_missed_count} + 9'(w_miss_pc);

  // Storage has no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_pixel) begin
    if (w_push) begin
      r_fifo_l[r_wr_ptr] <= w_left24;
      r_fifo_r[r_wr_ptr] <= w_right24;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_acr_pending   <= 1'b0;
      r_stale         <= '0;
      r_field_cnt     <= '0;
      r_pending       <= '1;
      r_frame_next    <= '0;
      r_packet_type   <= '0;
      r_packet_source <= '0;
      r_audio_group   <= '0;
      r_audio_present <= '0;
      r_frame_counter <= '0;
      r_missed_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      // a pop of 4 wraps to the same pointer when FIFO_DEPTH is 4
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      // ACR has top priority, so any slot serves a pending or arriving request
      if (bus.packet_enable) r_acr_pending <= 1'b0;
      else if (bus.acr_request) r_acr_pending <= 1'b1;

      if (bus.packet_enable && w_audio_sel) r_stale <= '0;
      else if (r_count == '0) r_stale <= '0;
      else if (bus.packet_enable && w_short && (r_stale != 2'd3)) r_stale <= r_stale + 2'd1;

      if (bus.video_field_end) begin
        r_field_cnt <= w_field_wrap ? 4'd0 : r_field_cnt + 4'd1;
      end

      // re-arm takes effect after this cycle's arbitration
      if (w_field_wrap) begin
        r_pending      <= '1;
        r_missed_count <= (w_miss_sum > 9'd255) ? 8'd255 : w_miss_sum[7:0];
      end else begin
        r_pending <= w_pend_after;
      end

      if (bus.packet_enable) begin
        r_packet_type   <= w_type;
        r_packet_source <= (w_sel == SEL_INFO) ? w_if_idx : 4'd0;
        r_audio_group   <= w_group;
        r_audio_present <= w_present;
        if (w_audio_sel) begin
          r_frame_counter <= r_frame_next;
          r_frame_next    <= w_fc_next;
        end
      end
    end
  end

  assign bus.sample_ready  = w_ready;
  assign bus.packet_type   = r_packet_type;
  assign bus.packet_source = r_packet_source;
  assign bus.audio_group   = r_audio_group;
  assign bus.audio_present = r_audio_present;
  assign bus.frame_counter = r_frame_counter;
  assign bus.missed_count  = r_missed_count;
endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler
//   Directed stimulus for packet_scheduler. Each packet slot pushes its
//   expected result into a queue; a monitor pops and compares on the cycle the
//   registered result appears. Audio payload expectations come from a model
//   queue of the samples the bench pushed.
module tb_packet_scheduler;
  localparam int NIF = 8;
  localparam int ABW = 24;

  typedef struct {
    logic [7:0]   ptype;
    logic [3:0]   src;
    logic [191:0] group;
    logic [3:0]   present;
    logic [7:0]   fc;
    bit           chk_fc;
  } exp_t;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;

  packet_scheduler_if #(.NUM_INFOFRAMES(NIF), .AUDIO_BIT_WIDTH(ABW)) bus ();

  packet_scheduler #(
    .NUM_INFOFRAMES(NIF), .AUDIO_BIT_WIDTH(ABW), .FIFO_DEPTH(8), .INFOFRAME_PERIOD(1)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  exp_t         exp_q[$];
  logic [47:0]  model_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           smp_id = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: a slot opened at a posedge shows its result by the following negedge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_pixel);
      if (bus.packet_enable === 1'b1 && reset === 1'b0) begin
        @(negedge clk_pixel);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_packet: got type %0h, expected no packet", bus.packet_type);
        end else begin
          e = exp_q.pop_front();
          check("packet_type",   bus.packet_type,   e.ptype);
          check("packet_source", bus.packet_source, e.src);
          check("audio_present", bus.audio_present, e.present);
          check("audio_group",   bus.audio_group,   e.group);
          if (e.chk_fc) check("frame_counter", bus.frame_counter, e.fc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_pixel);
  endtask

  task automatic do_reset();
    @(negedge clk_pixel);
    reset = 1'b1;
    model_q.delete();
    #1;
    check("rst_packet_type",   bus.packet_type,   8'h00);
    check("rst_packet_source", bus.packet_source, 4'h0);
    check("rst_audio_group",   bus.audio_group,   192'h0);
    check("rst_audio_present", bus.audio_present, 4'h0);
    check("rst_frame_counter", bus.frame_counter, 8'h00);
    check("rst_missed_count",  bus.missed_count,  8'h00);
    check("rst_sample_ready",  bus.sample_ready,  1'b1);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    reset = 1'b0;
  endtask

  task automatic push(input bit accept);
    logic [23:0] l;
    logic [23:0] r;
    l = 24'h100000 + 24'(smp_id);
    r = 24'h200000 + 24'(smp_id);
    smp_id++;
    bus.sample_valid = 1'b1;
    bus.sample_left  = l;
    bus.sample_right = r;
    if (accept) model_q.push_back({r, l});
    @(negedge clk_pixel);
    bus.sample_valid = 1'b0;
  endtask

  task automatic slot(input logic [7:0] t, input logic [3:0] src, input int n,
                      input logic [7:0] fc, input bit acr, input bit fe);
    exp_t e;
    e.ptype   = t;
    e.src     = src;
    e.present = 4'((1 << n) - 1);
    e.group   = '0;
    e.fc      = fc;
    e.chk_fc  = (n != 0);
    for (int k = 0; k < n; k++) begin
      if (model_q.size() != 0) e.group[48*k +: 48] = model_q.pop_front();
    end
    exp_q.push_back(e);
    bus.packet_enable   = 1'b1;
    bus.acr_request     = acr;
    bus.video_field_end = fe;
    @(negedge clk_pixel);
    bus.packet_enable   = 1'b0;
    bus.acr_request     = 1'b0;
    bus.video_field_end = 1'b0;
  endtask

  task automatic field_end();
    bus.video_field_end = 1'b1;
    @(negedge clk_pixel);
    bus.video_field_end = 1'b0;
  endtask

  task automatic acr_pulse();
    bus.acr_request = 1'b1;
    @(negedge clk_pixel);
    bus.acr_request = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: got no end of stimulus, expected finish within 1 ms");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin : stimulus
    bus.video_field_end  = 1'b0;
    bus.packet_enable    = 1'b0;
    bus.acr_request      = 1'b0;
    bus.sample_valid     = 1'b0;
    bus.sample_left      = '0;
    bus.sample_right     = '0;
    bus.infoframe_enable = 8'hFF;
    for (int i = 0; i < NIF; i++) bus.infoframe_type[8*i +: 8] = 8'h80 + 8'(i);

    // InfoFrames in slot order, then null
    do_reset();
    for (int i = 0; i < NIF; i++) slot(8'h80 + 8'(i), 4'(i), 0, 8'h00, 0, 0);
    slot(8'h00, 4'd0, 0, 8'h00, 0, 0);

    // 6 samples: full group, InfoFrame, then stale partial of 2
    do_reset();
    repeat (6) push(1);
    slot(8'h02, 4'd0, 4, 8'd0, 0, 0);
    slot(8'h80, 4'd0, 0, 8'd0, 0, 0);
    slot(8'h02, 4'd0, 2, 8'd4, 0, 0);
    idle(3);
    check("hold_packet_type",   bus.packet_type,   8'h02);
    check("hold_audio_present", bus.audio_present, 4'b0011);

    // ACR beats audio; latched requests merge into one ACR
    do_reset();
    repeat (4) push(1);
    slot(8'h01, 4'd0, 0, 8'd0, 1, 0);
    slot(8'h02, 4'd0, 4, 8'd0, 0, 0);
    acr_pulse();
    acr_pulse();
    idle(2);
    slot(8'h01, 4'd0, 0, 8'd0, 0, 0);
    slot(8'h80, 4'd0, 0, 8'd0, 0, 0);

    // full FIFO refuses a push and keeps order
    do_reset();
    repeat (8) push(1);
    check("full_sample_ready", bus.sample_ready, 1'b0);
    push(0);
    check("full_still_not_ready", bus.sample_ready, 1'b0);
    slot(8'h02, 4'd0, 4, 8'd0, 0, 0);
    check("after_pop_ready", bus.sample_ready, 1'b1);
    slot(8'h02, 4'd0, 4, 8'd4, 0, 0);
    slot(8'h80, 4'd0, 0, 8'd0, 0, 0);

    // missed InfoFrames, coincident field end and slot, saturation
    do_reset();
    bus.infoframe_enable = 8'h07;
    field_end();
    idle(1);
    check("missed_three", bus.missed_count, 8'd3);
    slot(8'h80, 4'd0, 0, 8'd0, 0, 0);
    slot(8'h81, 4'd1, 0, 8'd0, 0, 0);
    field_end();
    idle(1);
    check("missed_four", bus.missed_count, 8'd4);
    bus.infoframe_enable = 8'h01;
    slot(8'h80, 4'd0, 0, 8'd0, 0, 0);
    slot(8'h00, 4'd0, 0, 8'd0, 0, 1);
    check("missed_coincident", bus.missed_count, 8'd4);
    slot(8'h80, 4'd0, 0, 8'd0, 0, 0);
    bus.infoframe_enable = 8'hFF;
    repeat (32) field_end();
    check("missed_saturate", bus.missed_count, 8'd255);

    // disabled slot keeps its pending bit
    do_reset();
    bus.infoframe_enable = 8'h00;
    slot(8'h00, 4'd0, 0, 8'd0, 0, 0);
    bus.infoframe_enable = 8'h08;
    slot(8'h83, 4'd3, 0, 8'd0, 0, 0);
    slot(8'h00, 4'd0, 0, 8'd0, 0, 0);

    // frame index wraps 188 + 4 -> 0
    do_reset();
    bus.infoframe_enable = 8'h00;
    for (int k = 0; k < 48; k++) begin
      repeat (4) push(1);
      slot(8'h02, 4'd0, 4, 8'((4 * k) % 192), 0, 0);
    end
    repeat (4) push(1);
    slot(8'h02, 4'd0, 4, 8'd0, 0, 0);

    // frame index wraps 190 + 3 -> 1 via partial groups
    do_reset();
    for (int k = 0; k < 47; k++) begin
      repeat (4) push(1);
      slot(8'h02, 4'd0, 4, 8'((4 * k) % 192), 0, 0);
    end
    repeat (2) push(1);
    slot(8'h00, 4'd0, 0, 8'd0, 0, 0);
    slot(8'h02, 4'd0, 2, 8'd188, 0, 0);
    repeat (3) push(1);
    slot(8'h00, 4'd0, 0, 8'd0, 0, 0);
    slot(8'h02, 4'd0, 3, 8'd190, 0, 0);
    repeat (4) push(1);
    slot(8'h02, 4'd0, 4, 8'd1, 0, 0);

    // reset with samples buffered and a result on the outputs
    bus.infoframe_enable = 8'hFF;
    do_reset();
    repeat (3) push(1);
    slot(8'h80, 4'd0, 0, 8'd0, 0, 0);
    do_reset();
    repeat (4) push(1);
    slot(8'h02, 4'd0, 4, 8'd0, 0, 0);

    idle(4);
    check("queue_drained", 192'(exp_q.size()), 192'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
